// File: rtl/onewire_pkg.sv
// onewire_pkg: shared timing constants, slot kinds and CRC helper
// for the 1-Wire transaction master.
package onewire_pkg;

  localparam int T_RST_LOW     = 480;
  localparam int T_PRES_SAMPLE = 550;
  localparam int T_RST_END     = 960;
  localparam int T_W1_LOW      = 6;
  localparam int T_W0_LOW      = 60;
  localparam int T_SLOT        = 70;
  localparam int T_REC         = 10;
  localparam int T_RD_SAMPLE   = 15;

  typedef enum logic [1:0] {
    SLOT_RST,
    SLOT_W0,
    SLOT_W1,
    SLOT_RD
  } slot_kind_e;

  // Dallas/Maxim CRC8, reflected poly 0x8C, one bit at a time
  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[0] ^ b;
    crc8_step = (crc >> 1) ^ (fb ? 8'h8C : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_slot_engine.sv
// onewire_slot_engine: times a single reset, write or read slot
// on the bus and reports the sampled bit and slot completion.
module onewire_slot_engine
  import onewire_pkg::*;
#(
  parameter int US = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  slot_kind_e kind,
  input  logic       line,
  output logic       drive_low,
  output logic       sample,
  output logic       smp_bit,
  output logic       done
);

  localparam int CW = $clog2(T_RST_END * US + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;
  logic [CW-1:0] t_low;
  logic [CW-1:0] t_smp;
  logic [CW-1:0] t_end;
  logic          has_smp;
  logic          active;

  assign nxt = cnt + CW'(1);

  always_comb begin
    t_low   = CW'(T_W1_LOW * US);
    t_smp   = '0;
    has_smp = 1'b0;
    t_end   = CW'((T_SLOT + T_REC) * US);
    unique case (kind)
      SLOT_RST: begin
        t_low   = CW'(T_RST_LOW * US);
        t_smp   = CW'(T_PRES_SAMPLE * US);
        has_smp = 1'b1;
        t_end   = CW'(T_RST_END * US);
      end
      SLOT_W0: t_low = CW'(T_W0_LOW * US);
      SLOT_W1: t_low = CW'(T_W1_LOW * US);
      SLOT_RD: begin
        t_smp   = CW'(T_RD_SAMPLE * US);
        has_smp = 1'b1;
      end
      default: t_low = CW'(T_W1_LOW * US);
    endcase
  end

  // done leads the slot end by two cycles so the next slot starts
  // exactly on the slot pitch once the master reacts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      drive_low <= 1'b0;
      sample    <= 1'b0;
      smp_bit   <= 1'b0;
      done      <= 1'b0;
    end else begin
      sample <= 1'b0;
      done   <= 1'b0;
      if (start) begin
        active    <= 1'b1;
        cnt       <= '0;
        drive_low <= 1'b1;
      end else if (active) begin
        cnt       <= nxt;
        drive_low <= (nxt < t_low);
        if (has_smp && cnt == t_smp) begin
          sample  <= 1'b1;
          smp_bit <= line;
        end
        if (nxt == t_end - CW'(2)) done <= 1'b1;
        if (nxt == t_end) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/onewire_txn_master.sv
// onewire_txn_master: host-commanded 1-Wire transaction sequencer
// (reset/presence, byte writes, byte reads, CRC8 check).
module onewire_txn_master
  import onewire_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 27_000_000,
  parameter int MAX_WR_BYTES = 4,
  parameter int MAX_RD_BYTES = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_skip_reset,
  input  logic [$clog2(MAX_WR_BYTES+1)-1:0] cmd_wr_len,
  input  logic [8*MAX_WR_BYTES-1:0]         cmd_wr_data,
  input  logic [$clog2(MAX_RD_BYTES+1)-1:0] cmd_rd_len,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [8*MAX_RD_BYTES-1:0]         rsp_rd_data,
  output logic                              rsp_no_presence,
  output logic                              rsp_crc_ok,
  output logic                              rsp_len_err,
  output logic                              ow_drive_low,
  input  logic                              ow_in
);

  localparam int US  = CLK_FREQ_HZ / 1_000_000;
  localparam int WLW = $clog2(MAX_WR_BYTES + 1);
  localparam int RLW = $clog2(MAX_RD_BYTES + 1);
  localparam int WBW = WLW + 3;
  localparam int RBW = RLW + 3;
  localparam int RIW = $clog2(8 * MAX_RD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SEQ,
    S_WR,
    S_RD,
    S_RSP
  } state_e;

  state_e                    state;
  logic [1:0]                sync;
  logic [8*MAX_WR_BYTES-1:0] wr_buf;
  logic [WBW-1:0]            wr_left;
  logic [RBW-1:0]            rd_left;
  logic [RIW-1:0]            rd_idx;
  logic [7:0]                crc;
  logic                      start;
  slot_kind_e                kind;
  logic                      smp;
  logic                      smp_bit;
  logic                      done;
  logic [WLW-1:0]            wr_cl;
  logic [RLW-1:0]            rd_cl;
  logic                      len_bad;

  always_comb begin
    wr_cl   = cmd_wr_len;
    rd_cl   = cmd_rd_len;
    len_bad = 1'b0;
    if (cmd_wr_len > WLW'(MAX_WR_BYTES)) begin
      wr_cl   = WLW'(MAX_WR_BYTES);
      len_bad = 1'b1;
    end
    if (cmd_rd_len > RLW'(MAX_RD_BYTES)) begin
      rd_cl   = RLW'(MAX_RD_BYTES);
      len_bad = 1'b1;
    end
  end

  onewire_slot_engine #(
    .US(US)
  ) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kind     (kind),
    .line     (sync[1]),
    .drive_low(ow_drive_low),
    .sample   (smp),
    .smp_bit  (smp_bit),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      sync            <= 2'b11;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rd_data     <= '0;
      rsp_no_presence <= 1'b0;
      rsp_crc_ok      <= 1'b0;
      rsp_len_err     <= 1'b0;
      wr_buf          <= '0;
      wr_left         <= '0;
      rd_left         <= '0;
      rd_idx          <= '0;
      crc             <= '0;
      start           <= 1'b0;
      kind            <= SLOT_RST;
    end else begin
      sync  <= {sync[0], ow_in};
      start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready       <= 1'b0;
            wr_buf          <= cmd_wr_data;
            wr_left         <= {wr_cl, 3'b000};
            rd_left         <= {rd_cl, 3'b000};
            rd_idx          <= '0;
            crc             <= '0;
            rsp_rd_data     <= '0;
            rsp_no_presence <= 1'b0;
            rsp_crc_ok      <= 1'b0;
            rsp_len_err     <= len_bad;
            if (cmd_skip_reset) begin
              state <= S_SEQ;
            end else begin
              state <= S_RST;
              start <= 1'b1;
              kind  <= SLOT_RST;
            end
          end
        end
        S_RST: begin
          if (smp) rsp_no_presence <= smp_bit;
          if (done) state <= S_SEQ;
        end
        S_SEQ: begin
          if (!rsp_no_presence && wr_left != '0) begin
            state <= S_WR;
            start <= 1'b1;
            kind  <= wr_buf[0] ? SLOT_W1 : SLOT_W0;
          end else if (!rsp_no_presence && rd_left != '0) begin
            state <= S_RD;
            start <= 1'b1;
            kind  <= SLOT_RD;
          end else begin
            state      <= S_RSP;
            rsp_valid  <= 1'b1;
            rsp_crc_ok <= (crc == 8'h00);
          end
        end
        S_WR: begin
          if (done) begin
            wr_buf  <= wr_buf >> 1;
            wr_left <= wr_left - WBW'(1);
            if (wr_left == WBW'(1)) begin
              state <= S_SEQ;
            end else begin
              start <= 1'b1;
              kind  <= wr_buf[1] ? SLOT_W1 : SLOT_W0;
            end
          end
        end
        S_RD: begin
          if (smp) begin
            rsp_rd_data[rd_idx] <= smp_bit;
            crc                 <= crc8_step(crc, smp_bit);
            rd_idx              <= rd_idx + RIW'(1);
          end
          if (done) begin
            rd_left <= rd_left - RBW'(1);
            if (rd_left == RBW'(1)) begin
              state <= S_SEQ;
            end else begin
              start <= 1'b1;
              kind  <= SLOT_RD;
            end
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_txn_master.sv
// tb_onewire_txn_master: directed transactions against a behavioural
// 1-Wire slave, with response and bus-pulse scoreboards.
`timescale 1ns/1ps
module tb_onewire_txn_master;

  localparam int UNIT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_skip_reset = 1'b0;
  logic [2:0]  cmd_wr_len = '0;
  logic [31:0] cmd_wr_data = '0;
  logic [3:0]  cmd_rd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [71:0] rsp_rd_data;
  logic        rsp_no_presence;
  logic        rsp_crc_ok;
  logic        rsp_len_err;
  logic        ow_drive_low;
  logic        ow_in;

  logic dev_low = 1'b0;
  bit   present = 1'b0;
  bit   await_rst = 1'b0;
  int   slot_cnt = 0;
  int   wr_slots = 0;
  bit   tx_q[$];
  int   plog_len[$];
  longint plog_t[$];

  typedef struct {
    logic [71:0] data;
    logic        np;
    logic        ok;
    logic        le;
  } rsp_t;

  rsp_t rsp_q[$];
  int   exp_len_q[$];
  int   total = 0;
  int   bad = 0;
  logic [7:0] sp [9];

  always #(UNIT/2) clk = ~clk;

  assign ow_in = ~(ow_drive_low | dev_low);

  onewire_txn_master #(
    .CLK_FREQ_HZ (1_000_000),
    .MAX_WR_BYTES(4),
    .MAX_RD_BYTES(9)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_skip_reset (cmd_skip_reset),
    .cmd_wr_len     (cmd_wr_len),
    .cmd_wr_data    (cmd_wr_data),
    .cmd_rd_len     (cmd_rd_len),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rd_data    (rsp_rd_data),
    .rsp_no_presence(rsp_no_presence),
    .rsp_crc_ok     (rsp_crc_ok),
    .rsp_len_err    (rsp_len_err),
    .ow_drive_low   (ow_drive_low),
    .ow_in          (ow_in)
  );

  // slave: logs every master low pulse, answers resets and read slots
  initial begin
    longint t0;
    int     len;
    bit     tx;
    bit     txb;
    forever begin
      @(posedge ow_drive_low);
      t0  = $time;
      tx  = 1'b0;
      txb = 1'b1;
      if (!await_rst && slot_cnt >= wr_slots && tx_q.size() > 0) begin
        tx  = 1'b1;
        txb = tx_q.pop_front();
        if (!txb) dev_low = 1'b1;
      end
      @(negedge ow_drive_low);
      len = int'(($time - t0) / UNIT);
      plog_len.push_back(len);
      plog_t.push_back(t0 / UNIT);
      if (len >= 400) begin
        slot_cnt  = 0;
        await_rst = 1'b0;
        if (present) begin
          #(20 * UNIT) dev_low = 1'b1;
          #(150 * UNIT) dev_low = 1'b0;
        end
      end else begin
        if (tx && !txb) begin
          if ($time < t0 + 30 * UNIT) #(t0 + 30 * UNIT - $time);
          dev_low = 1'b0;
        end
        slot_cnt++;
      end
    end
  end

  initial begin
    #(80_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input int n);
    logic [7:0] c;
    logic [7:0] x;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      x = sp[i];
      for (int b = 0; b < 8; b++) begin
        if ((c[0] ^ x[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else c = c >> 1;
        x = x >> 1;
      end
    end
    return c;
  endfunction

  task automatic setup(input bit pres, input bit arst, input int wslots);
    present   = pres;
    await_rst = arst;
    wr_slots  = wslots;
    slot_cnt  = 0;
    tx_q.delete();
    plog_len.delete();
    plog_t.delete();
    exp_len_q.delete();
  endtask

  task automatic load_tx(input int n);
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 8; b++) tx_q.push_back(sp[j][b]);
  endtask

  task automatic push_wr_pulses(input logic [31:0] wd, input int nbits);
    for (int i = 0; i < nbits; i++) exp_len_q.push_back(wd[i] ? 6 : 60);
  endtask

  task automatic send_cmd(input logic skip, input logic [2:0] wl,
                          input logic [31:0] wd, input logic [3:0] rl);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid      = 1'b1;
    cmd_skip_reset = skip;
    cmd_wr_len     = wl;
    cmd_wr_data    = wd;
    cmd_rd_len     = rl;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic get_rsp(input int hold);
    int   n;
    rsp_t e;
    logic [71:0] d0;
    logic stable;
    n = 0;
    while (!rsp_valid && n < 15000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrives", rsp_valid, 1);
    if (!rsp_valid || rsp_q.size() == 0) return;
    e = rsp_q.pop_front();
    check("rsp_rd_data", rsp_rd_data, e.data);
    check("rsp_no_presence", rsp_no_presence, e.np);
    check("rsp_crc_ok", rsp_crc_ok, e.ok);
    check("rsp_len_err", rsp_len_err, e.le);
    if (hold > 0) begin
      d0     = rsp_rd_data;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rd_data !== d0 ||
            rsp_len_err !== e.le || rsp_crc_ok !== e.ok)
          stable = 1'b0;
      end
      check("rsp_hold_stable", stable, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("back_idle", cmd_ready, 1);
  endtask

  task automatic check_pulses(input string tag);
    int e;
    int o;
    check({tag, "_count"}, 72'(plog_len.size()), 72'(exp_len_q.size()));
    while (exp_len_q.size() > 0) begin
      e = exp_len_q.pop_front();
      o = (plog_len.size() > 0) ? plog_len.pop_front() : -1;
      check(tag, 72'(o), 72'(e));
    end
  endtask

  initial begin
    rsp_t r;
    logic [71:0] d;
    int n;
    bit seen_rsp;
    bit seen_drv;

    sp = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_drive", ow_drive_low, 0);
    check("rst_rd_data", rsp_rd_data, 0);
    check("rst_crc_ok", rsp_crc_ok, 0);
    rst_n = 1'b1;

    // 1: presence, write 0xCC 0x44, no read
    setup(1'b1, 1'b1, 16);
    exp_len_q.push_back(480);
    push_wr_pulses(32'h0000_44CC, 16);
    r = '{data: 72'h0, np: 1'b0, ok: 1'b1, le: 1'b0};
    rsp_q.push_back(r);
    send_cmd(1'b0, 3'd2, 32'h0000_44CC, 4'd0);
    get_rsp(0);
    if (plog_t.size() >= 3) check("t1_slot_pitch", 72'(plog_t[2] - plog_t[1]), 72'd80);
    else check("t1_slot_pitch_present", 72'(plog_t.size()), 72'd3);
    check_pulses("t1_pulse");

    // 2: no device answers the reset
    setup(1'b0, 1'b1, 8);
    exp_len_q.push_back(480);
    r = '{data: 72'h0, np: 1'b1, ok: 1'b1, le: 1'b0};
    rsp_q.push_back(r);
    send_cmd(1'b0, 3'd1, 32'h0000_00CC, 4'd2);
    get_rsp(0);
    check_pulses("t2_pulse");

    // 3: DS18B20 scratchpad read, then with one corrupted bit
    for (int k = 0; k < 2; k++) begin
      if (k == 1) sp[2] = sp[2] ^ 8'h01;
      setup(1'b1, 1'b1, 0);
      load_tx(9);
      exp_len_q.push_back(480);
      for (int i = 0; i < 72; i++) exp_len_q.push_back(6);
      d = '0;
      for (int j = 0; j < 9; j++) d[8*j +: 8] = sp[j];
      r = '{data: d, np: 1'b0, ok: (crc_model(9) == 8'h00), le: 1'b0};
      rsp_q.push_back(r);
      send_cmd(1'b0, 3'd0, 32'h0, 4'd9);
      get_rsp(0);
      check_pulses(k == 0 ? "t3_pulse" : "t3f_pulse");
    end
    sp[2] = sp[2] ^ 8'h01;

    // 4: skip reset, single read byte
    sp[0] = 8'hA5;
    setup(1'b1, 1'b0, 0);
    load_tx(1);
    for (int i = 0; i < 8; i++) exp_len_q.push_back(6);
    r = '{data: 72'hA5, np: 1'b0, ok: (crc_model(1) == 8'h00), le: 1'b0};
    rsp_q.push_back(r);
    send_cmd(1'b1, 3'd0, 32'h0, 4'd1);
    get_rsp(0);
    check_pulses("t4_pulse");
    sp[0] = 8'h50;

    // 5: reset asserted in the middle of a write-0 slot
    setup(1'b1, 1'b1, 8);
    send_cmd(1'b0, 3'd1, 32'h0, 4'd0);
    n = 0;
    while (plog_len.size() < 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!ow_drive_low && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    check("t5_w0_low", ow_drive_low, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_drive_rel", ow_drive_low, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    seen_rsp = 1'b0;
    seen_drv = 1'b0;
    repeat (1200) begin
      @(negedge clk);
      seen_rsp |= rsp_valid;
      seen_drv |= ow_drive_low;
    end
    check("t5_no_rsp", seen_rsp, 0);
    check("t5_bus_quiet", seen_drv, 0);

    // 6: wr_len over the limit is clamped, response held 50 cycles
    setup(1'b1, 1'b0, 32);
    push_wr_pulses(32'h1234_5678, 32);
    r = '{data: 72'h0, np: 1'b0, ok: 1'b1, le: 1'b1};
    rsp_q.push_back(r);
    send_cmd(1'b1, 3'd7, 32'h1234_5678, 4'd0);
    get_rsp(50);
    check_pulses("t6_pulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
